// File: rtl/decode_stage.sv
// RV32 ALU-instruction decode stage: reads the register file, builds the execute-stage
// operand/control bundle and holds it in a valid/ready pipeline register.
module decode_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [31:0] FD_instr,
    input  logic        FD_valid,
    output logic        FD_ready,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic [31:0] DE_in1,
    output logic [31:0] DE_in2,
    output logic [3:0]  DE_control,
    output logic [4:0]  DE_rd,
    output logic        DE_reg_write,
    output logic        DE_illegal,
    output logic        DE_valid,
    input  logic        DE_ready,
    output logic [31:0] DE_count
);

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SLL  = 4'b0011,
        ALU_SUB  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_MUL  = 4'b0110,
        ALU_XOR  = 4'b0111,
        ALU_SLTU = 4'b1000
    } alu_op_e;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [31:0] imm_i;

    logic [31:0] dec_in1;
    logic [31:0] dec_in2;
    alu_op_e     dec_op;
    logic        dec_legal;
    logic [3:0]  dec_control;
    logic        accept;

    assign opcode   = FD_instr[6:0];
    assign rd       = FD_instr[11:7];
    assign funct3   = FD_instr[14:12];
    assign rs1_addr = FD_instr[19:15];
    assign rs2_addr = FD_instr[24:20];
    assign funct7   = FD_instr[31:25];
    assign imm_i    = {{20{FD_instr[31]}}, FD_instr[31:20]};

    assign FD_ready = !flush && (!DE_valid || DE_ready);
    assign accept   = FD_valid && FD_ready;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        dec_in1   = '0;
        dec_in2   = '0;
        dec_op    = ALU_ADD;
        dec_legal = 1'b0;
        unique case (opcode)
            OP_R: begin
                dec_in1 = rs1_data;
                dec_in2 = rs2_data;
                unique case (funct7)
                    F7_BASE: begin
                        dec_legal = 1'b1;
                        unique case (funct3)
                            3'b000: dec_op = ALU_ADD;
                            3'b111: dec_op = ALU_AND;
                            3'b110: dec_op = ALU_OR;
                            3'b100: dec_op = ALU_XOR;
                            3'b011: dec_op = ALU_SLTU;
                            3'b001: begin
                                dec_op  = ALU_SLL;
                                dec_in2 = {27'd0, rs2_data[4:0]};
                            end
                            3'b101: begin
                                dec_op  = ALU_SRL;
                                dec_in2 = {27'd0, rs2_data[4:0]};
                            end
                            default: dec_legal = 1'b0;  // SLT
                        endcase
                    end
                    F7_ALT: begin
                        if (funct3 == 3'b000) begin
                            dec_op    = ALU_SUB;
                            dec_legal = 1'b1;
                        end
                    end
                    F7_MUL: begin
                        if (funct3 == 3'b000) begin
                            dec_op    = ALU_MUL;
                            dec_legal = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            OP_I: begin
                dec_in1   = rs1_data;
                dec_in2   = imm_i;
                dec_legal = 1'b1;
                unique case (funct3)
                    3'b000: dec_op = ALU_ADD;
                    3'b111: dec_op = ALU_AND;
                    3'b110: dec_op = ALU_OR;
                    3'b100: dec_op = ALU_XOR;
                    3'b011: dec_op = ALU_SLTU;
                    // Shift-immediates are only legal with imm[11:5] clear; SRAI falls out here.
                    3'b001: begin
                        dec_op    = ALU_SLL;
                        dec_legal = (funct7 == F7_BASE);
                        if (dec_legal) dec_in2 = {27'd0, FD_instr[24:20]};
                    end
                    3'b101: begin
                        dec_op    = ALU_SRL;
                        dec_legal = (funct7 == F7_BASE);
                        if (dec_legal) dec_in2 = {27'd0, FD_instr[24:20]};
                    end
                    default: dec_legal = 1'b0;  // SLTI
                endcase
            end
            default: ;
        endcase
    end

    // Illegal instructions travel as a harmless ADD with writeback suppressed.
    assign dec_control = dec_legal ? dec_op : ALU_ADD;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            DE_in1       <= '0;
            DE_in2       <= '0;
            DE_control   <= '0;
            DE_rd        <= '0;
            DE_reg_write <= 1'b0;
            DE_illegal   <= 1'b0;
            DE_valid     <= 1'b0;
            DE_count     <= '0;
        end else begin
            if (flush) begin
                DE_valid <= 1'b0;
            end else if (accept) begin
                DE_in1       <= dec_in1;
                DE_in2       <= dec_in2;
                DE_control   <= dec_control;
                DE_rd        <= rd;
                DE_reg_write <= dec_legal && (rd != 5'd0);
                DE_illegal   <= !dec_legal;
                DE_valid     <= 1'b1;
            end else if (DE_ready) begin
                DE_valid <= 1'b0;
            end
            if (accept && dec_legal) DE_count <= DE_count + 32'd1;
        end
    end

endmodule
